// File: rtl/divpipe.sv
// divpipe: fully pipelined unsigned 8-bit / 4-bit restoring divider.
//
// One operand pair is accepted every cycle and there is no backpressure.
// Stage 0 registers the inputs. Stages 1..8 each retire one quotient bit,
// starting with the MSB. Results appear on the stage-8 registers. An operand
// sampled on edge E is therefore visible after edge E+8.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst       in   1  asynchronous active-low reset, clears every register
//   in_valid  in   1  dvnd/dvsr are sampled this cycle
//   dvnd      in   8  unsigned dividend
//   dvsr      in   4  unsigned divisor
//   out_valid out  1  quot/rem/dbz carry a result
//   quot      out  8  floor(dvnd/dvsr); 8'hFF when dbz
//   rem       out  4  dvnd - quot*dvsr; 0 when dbz
//   dbz       out  1  the divisor of this result was zero
//
// Any stage that receives an invalid slot loads all zeros. As a result, the
// outputs are exactly zero whenever out_valid is low.
module divpipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] dvnd,
    input  logic [3:0] dvsr,
    output logic       out_valid,
    output logic [7:0] quot,
    output logic [3:0] rem,
    output logic       dbz
);

    // ------------------------------------------------------------------
    // Stage 0: input register
    // ------------------------------------------------------------------
    logic       v0_reg;
    logic [7:0] dvnd0_reg;
    logic [3:0] dvsr0_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_reg    <= 1'b0;
            dvnd0_reg <= 8'd0;
            dvsr0_reg <= 4'd0;
        end else begin
            v0_reg    <= in_valid;
            dvnd0_reg <= in_valid ? dvnd : 8'd0;
            dvsr0_reg <= in_valid ? dvsr : 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Stages 1..7: one quotient bit each.
    //
    // Stage k consumes dividend bit 8-k. It passes on only the bits that are
    // still unconsumed, so its dividend register narrows to 8-k bits.
    //
    // The partial remainder is held in 4 bits. After a restoring step it is
    // always below the divisor, so bit 4 of the 5-bit remainder is always
    // zero. In the divide-by-zero case the datapath value is discarded at
    // stage 8, so dropping that bit is harmless there as well.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 1; gi <= 7; gi++) begin : stg
            localparam int RW = 8 - gi;   // dividend bits kept after this stage

            logic        in_v;
            logic [3:0]  in_r;
            logic [7:0]  in_q;
            logic [RW:0] in_d;
            logic [3:0]  in_s;
            logic        in_z;

            if (gi == 1) begin : src
                assign in_v = v0_reg;
                assign in_r = 4'd0;
                assign in_q = 8'd0;
                assign in_d = dvnd0_reg;
                assign in_s = dvsr0_reg;
                assign in_z = (dvsr0_reg == 4'd0);
            end else begin : src
                assign in_v = stg[gi-1].v_reg;
                assign in_r = stg[gi-1].r_reg;
                assign in_q = stg[gi-1].q_reg;
                assign in_d = stg[gi-1].d_reg;
                assign in_s = stg[gi-1].s_reg;
                assign in_z = stg[gi-1].z_reg;
            end

            logic [4:0] t;
            logic       ge;
            logic [3:0] r_next;
            logic [7:0] q_next;

            always_comb begin
                t              = {in_r, in_d[RW]};
                ge             = (t >= {1'b0, in_s});
                r_next         = ge ? 4'(t - {1'b0, in_s}) : t[3:0];
                q_next         = in_q;
                q_next[8 - gi] = ge;
            end

            logic          v_reg;
            logic [3:0]    r_reg;
            logic [7:0]    q_reg;
            logic [RW-1:0] d_reg;
            logic [3:0]    s_reg;
            logic          z_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_reg <= 1'b0;
                    r_reg <= 4'd0;
                    q_reg <= 8'd0;
                    d_reg <= '0;
                    s_reg <= 4'd0;
                    z_reg <= 1'b0;
                end else if (in_v) begin
                    v_reg <= 1'b1;
                    r_reg <= r_next;
                    q_reg <= q_next;
                    d_reg <= in_d[RW-1:0];
                    s_reg <= in_s;
                    z_reg <= in_z;
                end else begin
                    v_reg <= 1'b0;
                    r_reg <= 4'd0;
                    q_reg <= 8'd0;
                    d_reg <= '0;
                    s_reg <= 4'd0;
                    z_reg <= 1'b0;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 8: last quotient bit. These registers drive the outputs
    // directly. A zero divisor overrides whatever the datapath produced.
    // ------------------------------------------------------------------
    logic [4:0] t8;
    logic       ge8;
    logic [3:0] r8_next;
    logic [7:0] q8_next;

    always_comb begin
        t8         = {stg[7].r_reg, stg[7].d_reg[0]};
        ge8        = (t8 >= {1'b0, stg[7].s_reg});
        r8_next    = ge8 ? 4'(t8 - {1'b0, stg[7].s_reg}) : t8[3:0];
        q8_next    = stg[7].q_reg;
        q8_next[0] = ge8;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            quot      <= 8'd0;
            rem       <= 4'd0;
            dbz       <= 1'b0;
        end else if (stg[7].v_reg) begin
            out_valid <= 1'b1;
            dbz       <= stg[7].z_reg;
            quot      <= stg[7].z_reg ? 8'hFF : q8_next;
            rem       <= stg[7].z_reg ? 4'd0  : r8_next;
        end else begin
            out_valid <= 1'b0;
            quot      <= 8'd0;
            rem       <= 4'd0;
            dbz       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_divpipe.sv
// tb_divpipe: self-checking bench for divpipe.
//
// Each stimulus cycle pushes the record it applies onto a history queue.
// One edge later, the outputs are compared against the record applied 9
// edges earlier. Before 9 records have accumulated since reset, the
// expected outputs are all zero.
module tb_divpipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] dvnd;
    logic [3:0] dvsr;
    logic       out_valid;
    logic [7:0] quot;
    logic [3:0] rem;
    logic       dbz;

    divpipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .dvnd      (dvnd),
        .dvsr      (dvsr),
        .out_valid (out_valid),
        .quot      (quot),
        .rem       (rem),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       v;
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;   // expected quotient (0 for a bubble)
        logic [3:0] r;   // expected remainder
        logic       z;   // expected dbz
    } vec_t;

    vec_t tbl [19];
    vec_t hist [$];
    int   passed  = 0;
    int   total   = 0;
    bit   verbose = 1'b1;

    task automatic check(input string name, input vec_t w);
        logic [13:0] got;
        logic [13:0] want;
        got  = {out_valid, quot, rem, dbz};
        want = {w.v, w.q, w.r, w.z};
        total++;
        if (got === want) begin
            passed++;
            if (verbose && w.v)
                $display("%-12s %3d / %2d -> quot=%3d rem=%2d dbz=%0d",
                         name, w.a, w.b, quot, rem, dbz);
        end else begin
            $display("FAIL %s: got valid=%0b quot=%0d rem=%0d dbz=%0b, want valid=%0b quot=%0d rem=%0d dbz=%0b",
                     name, out_valid, quot, rem, dbz, w.v, w.q, w.r, w.z);
        end
    endtask

    function automatic vec_t zero_vec(input string name);
        vec_t z;
        z = '{name, 1'b0, 8'd0, 4'd0, 8'd0, 4'd0, 1'b0};
        return z;
    endfunction

    // Apply one record for one clock, then check the result that is due now.
    task automatic cycle(input vec_t e);
        vec_t w;
        in_valid = e.v;
        dvnd     = e.a;
        dvsr     = e.b;
        hist.push_back(e);
        @(posedge clk);
        #1;
        while (hist.size() > 9) void'(hist.pop_front());
        if (hist.size() == 9) w = hist[0];
        else                  w = zero_vec("drain");
        check(w.name, w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(zero_vec("idle"));
    endtask

    function automatic vec_t model(input logic [7:0] a, input logic [3:0] b);
        vec_t e;
        if (b == 4'd0) e = '{"exh_dbz", 1'b1, a, b, 8'hFF, 4'd0, 1'b1};
        else           e = '{"exh", 1'b1, a, b, 8'(a / b), 4'(a % b), 1'b0};
        return e;
    endfunction

    initial begin
        tbl[0]  = '{"d200_7",     1'b1, 8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
        tbl[1]  = '{"d255_15",    1'b1, 8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
        tbl[2]  = '{"d13_14",     1'b1, 8'd13,  4'd14, 8'd0,   4'd13, 1'b0};
        tbl[3]  = '{"d255_1",     1'b1, 8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
        tbl[4]  = '{"dbz100_0",   1'b1, 8'd100, 4'd0,  8'hFF,  4'd0,  1'b1};
        tbl[5]  = '{"dbz0_0",     1'b1, 8'd0,   4'd0,  8'hFF,  4'd0,  1'b1};
        tbl[6]  = '{"d100_3",     1'b1, 8'd100, 4'd3,  8'd33,  4'd1,  1'b0};
        tbl[7]  = '{"bub50_6",    1'b1, 8'd50,  4'd6,  8'd8,   4'd2,  1'b0};
        tbl[8]  = '{"bub_gap0",   1'b0, 8'd77,  4'd5,  8'd0,   4'd0,  1'b0};
        tbl[9]  = '{"bub9_4",     1'b1, 8'd9,   4'd4,  8'd2,   4'd1,  1'b0};
        tbl[10] = '{"bub250_13",  1'b1, 8'd250, 4'd13, 8'd19,  4'd3,  1'b0};
        tbl[11] = '{"bub_gap1",   1'b0, 8'd11,  4'd3,  8'd0,   4'd0,  1'b0};
        tbl[12] = '{"bub_gap2",   1'b0, 8'd0,   4'd0,  8'd0,   4'd0,  1'b0};
        tbl[13] = '{"bub15_15",   1'b1, 8'd15,  4'd15, 8'd1,   4'd0,  1'b0};
        tbl[14] = '{"d0_5",       1'b1, 8'd0,   4'd5,  8'd0,   4'd0,  1'b0};
        tbl[15] = '{"d1_1",       1'b1, 8'd1,   4'd1,  8'd1,   4'd0,  1'b0};
        tbl[16] = '{"d5_9",       1'b1, 8'd5,   4'd9,  8'd0,   4'd5,  1'b0};
        tbl[17] = '{"d200_1",     1'b1, 8'd200, 4'd1,  8'd200, 4'd0,  1'b0};
        tbl[18] = '{"d7_7",       1'b1, 8'd7,   4'd7,  8'd1,   4'd0,  1'b0};

        // ---- reset: asynchronous assertion, then held with busy inputs ----
        in_valid = 1'b0;
        dvnd     = 8'd0;
        dvsr     = 4'd0;
        rst      = 1'b1;
        #1 rst   = 1'b0;
        #1 check("reset_async", zero_vec("reset_async"));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            dvnd     = 8'($urandom);
            dvsr     = 4'($urandom);
            check("reset_edge", zero_vec("reset_edge"));
            @(negedge clk);
            check("reset_mid", zero_vec("reset_mid"));
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        hist.delete();
        idle(12);

        // ---- directed values, divide by zero, bubbles, boundaries ----
        for (int i = 0; i < 19; i++) cycle(tbl[i]);

        // ---- async reset with five operations in flight ----
        cycle('{"inflight0", 1'b1, 8'd10, 4'd3, 8'd3,  4'd1, 1'b0});
        cycle('{"inflight1", 1'b1, 8'd20, 4'd3, 8'd6,  4'd2, 1'b0});
        cycle('{"inflight2", 1'b1, 8'd30, 4'd3, 8'd10, 4'd0, 1'b0});
        cycle('{"inflight3", 1'b1, 8'd40, 4'd3, 8'd13, 4'd1, 1'b0});
        in_valid = 1'b1;
        dvnd     = 8'd50;
        dvsr     = 4'd3;
        #3 rst   = 1'b0;
        #1 check("async_drop", zero_vec("async_drop"));
        @(posedge clk);
        #1 check("held_reset", zero_vec("held_reset"));
        in_valid = 1'b0;
        #2 rst   = 1'b1;
        hist.delete();
        idle(3);
        cycle('{"post_rst9_2", 1'b1, 8'd9, 4'd2, 8'd4, 4'd1, 1'b0});
        idle(12);

        // ---- every operand pair, with random bubbles ----
        verbose = 1'b0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    vec_t bub;
                    bub   = zero_vec("exh_bubble");
                    bub.a = 8'($urandom);
                    bub.b = 4'($urandom);
                    cycle(bub);
                end
                cycle(model(8'(a), 4'(b)));
            end
        end
        idle(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/divpipe.md
# divpipe

Fully pipelined unsigned 8-bit by 4-bit restoring divider producing an 8-bit quotient and 4-bit remainder. It is the inverse of the team's 4x4 pipelined shift-add multiplier: the multiplier accumulates one partial product per stage, and this block retires one quotient bit per stage. It accepts one operand pair per cycle with no backpressure and sits in the same arithmetic datapath. A valid bit travels alongside the data, so idle cycles are explicit and outputs are deterministic.

## Interface
- Parameters: none; widths are fixed at dividend 8, divisor 4, quotient 8, remainder 4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; clears every register immediately while low.
- `in_valid`  in  1  operand pair on `dvnd`/`dvsr` is sampled this cycle.
- `dvnd`  in  8  unsigned dividend.
- `dvsr`  in  4  unsigned divisor.
- `out_valid`  out  1  `quot`/`rem`/`dbz` carry a result this cycle.
- `quot`  out  8  unsigned quotient, floor(dvnd/dvsr).
- `rem`  out  4  remainder, dvnd - quot*dvsr.
- `dbz`  out  1  divide-by-zero flag for the result on the outputs.

## Operation
- **Stage 0 (input register)** captures `in_valid`, `dvnd`, and `dvsr`.
  - If `in_valid`=0, its data registers load 0.
- **Stages 1..8** each carry these registers:
  - valid bit
  - 5-bit partial remainder `r`
  - 8-bit partial quotient
  - the remaining dividend bits
  - divisor
  - dbz bit
- **Stage k** (k=1..8) processes dividend bit i=8-k, MSB first:
  - Shift: t = {r[3:0], dvnd[i]}. This is 5 bits and is zero-extended for the compare.
  - If t >= {1'b0, dvsr}: r_next = t - dvsr and q[i] = 1.
  - Otherwise: r_next = t and q[i] = 0.
  - The stage 1 input has r = 0.
- Invariant: r < dvsr after every stage when dvsr≠0, so r[4] is always 0 on stage outputs.
- **Divide by zero:** dbz = (dvsr == 0) is computed in stage 1 and carried forward.
  - At stage 8, dbz forces quot = 8'hFF and rem = 4'h0, whatever the datapath computed.
- **Bubbles:** when a stage's valid input is 0, that stage loads valid=0 and all data registers load 0.
  - Consequence: `quot`, `rem`, and `dbz` are exactly 0 whenever `out_valid`=0.
- The outputs are the stage 8 registers directly. There is no combinational path from inputs to outputs.
- No stall or flush input. Every stage advances every cycle.

## Timing
- Reset: while `rst`=0, every register is 0.
  - `out_valid`=0, `quot`=8'h00, `rem`=4'h0, `dbz`=0.
  - Takes effect asynchronously, without waiting for a clock edge.
  - Release is synchronous to the next rising edge at the earliest.
- Latency: an operand pair sampled on rising edge E appears on outputs after edge E+8. That is 9 register stages, with the result visible during the 9th cycle after sampling.
- Throughput: 1 result per cycle. N back-to-back valid inputs produce N consecutive valid outputs in order.
- Bubbles are preserved: the `in_valid` pattern reappears on `out_valid` delayed by 9 edges, bit for bit.
- Reset mid-operation: all in-flight operations are discarded.
  - No valid output appears from pre-reset operations.
  - After release, the first `out_valid` is the first pair sampled after release, 9 edges later.
- Boundaries:
  - dvnd < dvsr gives quot=0, rem=dvnd.
  - dvsr=1 gives quot=dvnd, rem=0.
  - dvnd=0, dvsr≠0 gives quot=0, rem=0, dbz=0.
  - dvnd=0, dvsr=0 gives dbz=1, quot=8'hFF, rem=0.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with random inputs and `in_valid`=1.
  - Outputs stay all-zero, including mid-cycle.
  - After release with `in_valid`=0, outputs stay zero indefinitely.
- **Directed values** (one per cycle, back-to-back) → results on 4 consecutive cycles starting 9 edges after the first:
  - 200/7 → quot=28, rem=4
  - 255/15 → quot=17, rem=0
  - 13/14 → quot=0, rem=13
  - 255/1 → quot=255, rem=0
- **Divide by zero:** 100/0 and 0/0.
  - Each gives `dbz`=1, `quot`=8'hFF, `rem`=0.
  - A following 100/3 gives `dbz`=0, `quot`=33, `rem`=1.
- **Bubble pattern:** `in_valid` = 1,0,1,1,0,0,1 with distinct operands.
  - `out_valid` shows the same pattern 9 edges later.
  - Data is 0 on the invalid cycles.
- **Async reset mid-flight:** start 5 back-to-back operations, drop `rst` between clock edges 4 cycles in.
  - `out_valid` falls immediately.
  - None of the 5 results ever appear.
  - A new 9/2 after release yields `quot`=4, `rem`=1 at +9 edges.
- **Exhaustive random:** all 4096 dvnd/dvsr pairs, streamed with random bubbles and compared against a scoreboard model.
  - dvsr≠0: quot*dvsr + rem == dvnd and rem < dvsr.
  - dvsr=0: the dbz rule holds.
